// File: rtl/video_scanout.sv
// video_scanout
//   Scans a 1-bpp bitmap out of the RAM's second read port and produces a
//   pixel stream with hsync/vsync/de timing. The bitmap is H_ACTIVE x V_ACTIVE
//   pixels, stored as WORDS_PER_ROW 16-bit words per row. Within a word the
//   LSB is the leftmost pixel. The framebuffer base is latched once per frame
//   so software can flip between buffers without tearing.
//
// Ports
//   clk          sole clock (also clocks the RAM second port)
//   reset        synchronous, active-high
//   enable       1 = scan, 0 = held in the reset state
//   fb_base      framebuffer base word address, latched once per frame
//   mem_addr     RAM second_address
//   mem_data     RAM second_out, valid the cycle after mem_addr
//   mem_rd       high on cycles where mem_addr is a real fetch
//   pixel        current pixel, 0 outside the active area
//   de           display enable
//   hsync/vsync  sync pulses, active level SYNC_POL
//   frame_start  one-cycle pulse at h=0, v=0
module video_scanout #(
  parameter int   H_ACTIVE      = 160,
  parameter int   H_FP          = 8,
  parameter int   H_SYNC        = 24,
  parameter int   H_BP          = 8,
  parameter int   V_ACTIVE      = 120,
  parameter int   V_FP          = 1,
  parameter int   V_SYNC        = 2,
  parameter int   V_BP          = 8,
  parameter int   WORDS_PER_ROW = H_ACTIVE / 16,
  parameter logic SYNC_POL      = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [14:0] fb_base,
  output logic [14:0] mem_addr,
  input  logic [15:0] mem_data,
  output logic        mem_rd,
  output logic        pixel,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_PRE        = HW'(H_TOTAL - 2);
  localparam logic [HW-1:0] H_ACT        = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LAST_FETCH = HW'(H_ACTIVE - 16);
  localparam logic [HW-1:0] H_SYNC_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT        = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_ACT_M1     = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_SYNC_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [14:0]   frame_base;
  logic [14:0]   row_base;
  logic [14:0]   addr_hold;
  logic [15:0]   prefetch;
  logic [15:0]   shift;
  logic          fetch_d;

  logic          h_last;
  logic          v_last;
  logic          next_line_active;
  logic          line_fetch;
  logic          mid_fetch;
  logic [14:0]   next_row_base;
  logic [14:0]   word_idx;
  logic [14:0]   fetch_addr;

  // Timing decode and fetch scheduling, all from registered state.
  // Word 0 of a line is fetched at the end of the previous line; words 1..N-1
  // are fetched two cycles before the word boundary where they are needed.
  always_comb begin
    h_last           = (h == H_LAST);
    v_last           = (v == V_LAST);
    de               = (h < H_ACT) && (v < V_ACT);
    next_line_active = v_last || (v < V_ACT_M1);
    next_row_base    = v_last ? 15'd0 : row_base + 15'(WORDS_PER_ROW);
    line_fetch       = (h == H_PRE) && next_line_active;
    mid_fetch        = de && (h[3:0] == 4'd14) && (h < H_LAST_FETCH);
    word_idx         = 15'(h[HW-1:4]) + 15'd1;
    mem_rd           = line_fetch || mid_fetch;
    fetch_addr       = line_fetch ? frame_base + next_row_base
                                  : frame_base + row_base + word_idx;
    mem_addr         = mem_rd ? fetch_addr : addr_hold;
    hsync            = ((h >= H_SYNC_START) && (h < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    vsync            = ((v >= V_SYNC_START) && (v < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    frame_start      = (h == '0) && (v == '0);
    // On the first pixel of a word the shifter has not been loaded yet, so
    // bit 0 comes straight from the prefetch register.
    pixel            = de && ((h[3:0] == 4'd0) ? prefetch[0] : shift[0]);
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      h          <= '0;
      v          <= V_LAST;
      frame_base <= '0;
      row_base   <= '0;
      addr_hold  <= '0;
      prefetch   <= '0;
      shift      <= '0;
      fetch_d    <= 1'b0;
    end else begin
      fetch_d   <= mem_rd;
      addr_hold <= mem_addr;
      if (fetch_d) begin
        prefetch <= mem_data;
      end
      // The shifter takes bits 1..15 of the word; bit 0 is shown from prefetch.
      if (de) begin
        shift <= (h[3:0] == 4'd0) ? (prefetch >> 1) : (shift >> 1);
      end
      // Latched on the last blank line, before the line-0 prefetch uses it.
      if ((h == '0) && v_last) begin
        frame_base <= fb_base;
      end
      if (h_last) begin
        h <= '0;
        v <= v_last ? '0 : v + VW'(1);
        if (v_last || (v < V_ACT)) begin
          row_base <= next_row_base;
        end
      end else begin
        h <= h + HW'(1);
      end
    end
  end

endmodule

// File: tb/tb_video_scanout.sv
// tb_video_scanout
//   Self-checking bench for video_scanout. A behavioural reference tracks the
//   raster position and frame base; expected fetch addresses go into a
//   scoreboard queue and are popped when the DUT raises mem_rd. Per-cycle
//   timing/pixel outputs are compared against the reference, and a few
//   frame-level figures (period, fetch counts, specific addresses) are
//   checked explicitly.
module tb_video_scanout;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [14:0] fb_base;
  logic [14:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_rd;
  logic        pixel;
  logic        de;
  logic        hsync;
  logic        vsync;
  logic        frame_start;

  video_scanout dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .fb_base     (fb_base),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_rd      (mem_rd),
    .pixel       (pixel),
    .de          (de),
    .hsync       (hsync),
    .vsync       (vsync),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM on the second port.
  logic [15:0] ram [0:32767];
  initial mem_data = 16'h0;
  always @(posedge clk) mem_data <= ram[mem_addr];

  int compareCount  = 0;
  int mismatchCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Reference raster state.
  int          mh = 0;
  int          mv = 130;
  logic [14:0] mbase = 15'h0;
  logic [14:0] mlast = 15'h0;

  function automatic bit expFetch(int h, int v);
    return (h == 198 && (v == 130 || v < 119)) ||
           (h < 160 && v < 120 && (h % 16) == 14 && h < 144);
  endfunction

  function automatic logic [14:0] expAddr(int h, int v, logic [14:0] base);
    int row;
    int w;
    if (h == 198) begin
      row = (v == 130) ? 0 : v + 1;
      w   = 0;
    end else begin
      row = v;
      w   = h / 16 + 1;
    end
    return base + 15'(row * 10 + w);
  endfunction

  function automatic logic expPixel(int h, int v, logic [14:0] base);
    logic [15:0] word;
    if (!(h < 160 && v < 120)) return 1'b0;
    word = ram[base + 15'(v * 10 + h / 16)];
    return word[h % 16];
  endfunction

  always @(posedge clk) begin
    if (reset || !enable) begin
      mh    <= 0;
      mv    <= 130;
      mbase <= 15'h0;
      mlast <= 15'h0;
    end else begin
      if (mh == 0 && mv == 130) mbase <= fb_base;
      if (expFetch(mh, mv)) mlast <= expAddr(mh, mv, mbase);
      if (mh == 199) begin
        mh <= 0;
        mv <= (mv == 130) ? 0 : mv + 1;
      end else begin
        mh <= mh + 1;
      end
    end
  end

  // Statistics gathered by the checker, cleared on request from the stimulus.
  bit          checking = 1'b0;
  int          clearGen = 0;
  int          seenGen = 0;
  logic [14:0] sbq [$];
  int          cyc = 0;
  bit          haveFs;
  int          lastFs;
  int          fetchSince;
  int          fsPeriod;
  int          frameFetches;
  bit          firstSeen;
  int          ffH, ffV;
  logic [14:0] ffAddr;
  int          l0Ones, l0Pos;
  logic [14:0] l119Pre, l119First, l119Last, preAddr, b0Addr;
  int          blankFetches;

  always @(negedge clk) begin
    logic [14:0] expA;
    logic [14:0] popped;
    bit          ef;
    if (clearGen != seenGen) begin
      seenGen      = clearGen;
      haveFs       = 0;
      fetchSince   = 0;
      fsPeriod     = -1;
      frameFetches = -1;
      firstSeen    = 0;
      ffH = -1; ffV = -1; ffAddr = 15'h7fff;
      l0Ones = 0; l0Pos = 0;
      blankFetches = 0;
    end
    if (checking) begin
      cyc++;
      ef   = expFetch(mh, mv);
      expA = ef ? expAddr(mh, mv, mbase) : mlast;
      checkOutput("de", 32'(de), 32'(mh < 160 && mv < 120));
      checkOutput("hsync", 32'(hsync), 32'((mh >= 168 && mh < 192) ? 0 : 1));
      checkOutput("vsync", 32'(vsync), 32'((mv >= 121 && mv < 123) ? 0 : 1));
      checkOutput("frame_start", 32'(frame_start), 32'(mh == 0 && mv == 0));
      checkOutput("mem_rd", 32'(mem_rd), 32'(ef));
      checkOutput("mem_addr", 32'(mem_addr), 32'(expA));
      checkOutput("pixel", 32'(pixel), 32'(expPixel(mh, mv, mbase)));
      if (ef) sbq.push_back(expA);
      if (mem_rd) begin
        if (sbq.size() > 0) begin
          popped = sbq.pop_front();
          checkOutput("sb_fetch_addr", 32'(mem_addr), 32'(popped));
        end else begin
          checkOutput("sb_unexpected_fetch", 32'(mem_rd), 32'(0));
        end
      end
      if (frame_start) begin
        if (haveFs) begin
          fsPeriod     = cyc - lastFs;
          frameFetches = fetchSince;
        end
        haveFs     = 1;
        lastFs     = cyc;
        fetchSince = 0;
      end
      if (mem_rd) begin
        fetchSince++;
        if (!firstSeen) begin
          firstSeen = 1; ffH = mh; ffV = mv; ffAddr = mem_addr;
        end
        if (mv == 118 && mh == 198) l119Pre = mem_addr;
        if (mv == 119 && mh == 14)  l119First = mem_addr;
        if (mv == 119 && mh == 142) l119Last = mem_addr;
        if (mv == 130 && mh == 198) preAddr = mem_addr;
        if (mv == 0 && mh == 14)    b0Addr = mem_addr;
        if (mv >= 120 && mv <= 129) blankFetches++;
      end
      if (pixel && mv == 0 && mbase == 15'h200) begin
        l0Ones++;
        l0Pos += mh;
      end
    end
  end

  // Drives inputs at the current (negedge) point, then waits.
  task automatic applyStimulus(input logic r, input logic e, input logic [14:0] fb,
                               input int cycles);
    reset   = r;
    enable  = e;
    fb_base = fb;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic waitFor(input int th, input int tv, input int budget);
    int n = 0;
    while (!(mh == th && mv == tv) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reach_pos", {16'(mv), 16'(mh)}, {16'(tv), 16'(th)});
  endtask

  task automatic checkBlank(input string which);
    checkOutput({which, "_de"}, 32'(de), 32'(0));
    checkOutput({which, "_pixel"}, 32'(pixel), 32'(0));
    checkOutput({which, "_hsync"}, 32'(hsync), 32'(1));
    checkOutput({which, "_vsync"}, 32'(vsync), 32'(1));
    checkOutput({which, "_mem_rd"}, 32'(mem_rd), 32'(0));
    checkOutput({which, "_mem_addr"}, 32'(mem_addr), 32'(0));
    checkOutput({which, "_frame_start"}, 32'(frame_start), 32'(0));
  endtask

  // Release from reset and confirm the startup fetch and line-0 pixels.
  task automatic restartAndCheck(input string which);
    clearGen++;
    applyStimulus(1'b0, 1'b1, 15'h200, 0);
    waitFor(0, 0, 400);
    checkOutput({which, "_first_fetch_h"}, 32'(ffH), 32'(198));
    checkOutput({which, "_first_fetch_v"}, 32'(ffV), 32'(130));
    checkOutput({which, "_first_fetch_addr"}, 32'(ffAddr), 32'h200);
    waitFor(0, 2, 800);
    checkOutput({which, "_line0_ones"}, 32'(l0Ones), 32'(2));
    checkOutput({which, "_line0_pos"}, 32'(l0Pos), 32'(31));
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) ram[i] = 16'((i * 40503) ^ (i >> 2));
    ram[15'h200] = 16'h0001;
    ram[15'h201] = 16'h8000;
    for (int i = 'h202; i <= 'h209; i++) ram[i] = 16'h0000;

    reset = 1'b1; enable = 1'b1; fb_base = 15'h200;
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 15'h200, 2);
    checking = 1'b1;
    checkBlank("reset_state");

    // Startup and frame A with 0x200; switch base mid-frame.
    restartAndCheck("start");
    waitFor(0, 60, 12000);
    applyStimulus(1'b0, 1'b1, 15'h000, 0);
    waitFor(0, 0, 27000);
    repeat (2) @(negedge clk);
    checkOutput("frame_period", 32'(fsPeriod), 32'(26200));
    checkOutput("frame_fetches", 32'(frameFetches), 32'(1200));
    checkOutput("line119_pre", 32'(l119Pre), 32'h6A6);
    checkOutput("line119_first", 32'(l119First), 32'h6A7);
    checkOutput("line119_last", 32'(l119Last), 32'h6AF);
    checkOutput("blank_fetches", 32'(blankFetches), 32'(0));
    checkOutput("frameB_prefetch", 32'(preAddr), 32'h000);

    // Frame B on base 0, then reset mid-line.
    waitFor(77, 40, 9000);
    checkOutput("frameB_line0_w1", 32'(b0Addr), 32'h001);
    applyStimulus(1'b1, 1'b1, 15'h200, 1);
    checkBlank("midreset");
    applyStimulus(1'b1, 1'b1, 15'h200, 2);
    restartAndCheck("after_reset");

    // Same again with enable dropped instead of reset.
    waitFor(77, 40, 9000);
    applyStimulus(1'b0, 1'b0, 15'h200, 1);
    checkBlank("disable");
    applyStimulus(1'b0, 1'b0, 15'h200, 2);
    restartAndCheck("after_enable");

    checkOutput("sb_leftover", 32'(sbq.size()), 32'(0));
    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
